// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one registered WIDTH-bit ALU between two requesters. Grants are
// round-robin. A requester may hold the grant across consecutive cycles with
// its lock bit, up to LOCK_MAX grants in a row. The issued op's negate bit is
// delayed by one cycle so that it lines up with the ALU's result cycle. The
// result and flags are captured and returned tagged with the requester id.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   reqN_valid / reqN_ready  per-requester handshake; an op issues on valid&&ready
//   reqN_x, reqN_y           operands
//   reqN_cfg                 {zero_x, zero_y, negate, opcode[1:0]}
//                            opcode 0=OR, 1=AND, 2=ADD, 3=SUB
//   reqN_lock                ask to keep the grant next cycle
//   alu_x, alu_y, alu_zero_x, alu_zero_y, alu_opcode
//                            ALU controls, driven from the granted requester
//   alu_negate               registered negate, valid in the ALU result cycle
//   alu_result, alu_is_zero, alu_is_negative
//                            ALU outputs, sampled in the result cycle
//   rsp_valid                one-cycle pulse; rsp_id/result/zero/neg valid
//   rsp_id, rsp_result, rsp_zero, rsp_neg
//                            captured response; held between pulses
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH    = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [4:0]       req0_cfg,
  input  logic             req0_lock,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [4:0]       req1_cfg,
  input  logic             req1_lock,

  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zero_x,
  output logic             alu_zero_y,
  output logic [1:0]       alu_opcode,
  output logic             alu_negate,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_is_zero,
  input  logic             alu_is_negative,

  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Arbiter state
  logic             prio_q,        prio_d;
  logic             lock_active_q, lock_active_d;
  logic             lock_owner_q,  lock_owner_d;
  logic [CNT_W-1:0] lock_cnt_q,    lock_cnt_d;

  // Stage 1: op in flight inside the ALU
  logic             inflight_q,    inflight_d;
  logic             id_q,          id_d;
  logic             negate_q,      negate_d;

  // Response registers
  logic             rsp_valid_q,   rsp_valid_d;
  logic             rsp_id_q,      rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q,  rsp_result_d;
  logic             rsp_zero_q,    rsp_zero_d;
  logic             rsp_neg_q,     rsp_neg_d;

  // Grant decode
  logic             hold;
  logic             arb_prio;
  logic             gnt0, gnt1;
  logic             issue;
  logic             gnt_lock;
  logic [4:0]       gnt_cfg;

  // ---------------------------------------------------------------------------
  // Grant: purely combinational from valids, locks and arbiter state.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on entry, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    hold     = 1'b0;
    arb_prio = prio_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;

    // The owner keeps the ALU only while it still asks for it and is under
    // the cap; otherwise the lock is dropped this very cycle and the other
    // requester is favoured, so a vanished owner never stalls it.
    if (lock_active_q && lock_cnt_q < LOCK_MAX_C) begin
      hold = lock_owner_q ? (req1_valid && req1_lock)
                          : (req0_valid && req0_lock);
    end
    if (lock_active_q) begin
      arb_prio = ~lock_owner_q;
    end

    if (!rst) begin
      if (hold) begin
        gnt0 = ~lock_owner_q;
        gnt1 =  lock_owner_q;
      end else if (req0_valid && req1_valid) begin
        gnt0 = ~arb_prio;
        gnt1 =  arb_prio;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign issue      = gnt0 | gnt1;
  assign gnt_lock   = gnt1 ? req1_lock : req0_lock;
  assign gnt_cfg    = gnt1 ? req1_cfg  : req0_cfg;

  // ---------------------------------------------------------------------------
  // ALU controls: idle value is OR of two zero operands.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_x      = '0;
    alu_y      = '0;
    alu_zero_x = 1'b0;
    alu_zero_y = 1'b0;
    alu_opcode = 2'd0;
    if (issue) begin
      alu_x      = gnt1 ? req1_x : req0_x;
      alu_y      = gnt1 ? req1_y : req0_y;
      alu_zero_x = gnt_cfg[4];
      alu_zero_y = gnt_cfg[3];
      alu_opcode = gnt_cfg[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    prio_d        = prio_q;
    lock_active_d = 1'b0;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = '0;

    if (issue) begin
      prio_d = ~gnt1;
    end else if (lock_active_q) begin
      prio_d = ~lock_owner_q;
    end

    if (hold) begin
      lock_active_d = 1'b1;
      lock_cnt_d    = lock_cnt_q + CNT_ONE;
    end else if (issue && gnt_lock) begin
      lock_active_d = 1'b1;
      lock_owner_d  = gnt1;
      lock_cnt_d    = CNT_ONE;
    end

    // Negate is cleared when nothing issues so alu_negate reads 0 whenever
    // the ALU holds no live op.
    inflight_d = issue;
    id_d       = issue ? gnt1 : id_q;
    negate_d   = issue & gnt_cfg[2];

    // Capture happens at the edge ending the ALU's result cycle.
    rsp_valid_d  = inflight_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    if (inflight_q) begin
      rsp_id_d     = id_q;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_is_zero;
      rsp_neg_d    = alu_is_negative;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q        <= 1'b0;
      lock_active_q <= 1'b0;
      lock_owner_q  <= 1'b0;
      lock_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      id_q          <= 1'b0;
      negate_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_neg_q     <= 1'b0;
    end else begin
      prio_q        <= prio_d;
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      inflight_q    <= inflight_d;
      id_q          <= id_d;
      negate_q      <= negate_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_neg_q     <= rsp_neg_d;
    end
  end

  assign alu_negate = negate_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_neg    = rsp_neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A small registered ALU sits behind the DUT.
// Expected responses are pushed to a scoreboard when an op is driven and are
// popped when rsp_valid pulses; grants and alu_negate are checked every cycle.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;

  logic             req0_valid, req0_ready, req0_lock;
  logic [WIDTH-1:0] req0_x, req0_y;
  logic [4:0]       req0_cfg;
  logic             req1_valid, req1_ready, req1_lock;
  logic [WIDTH-1:0] req1_x, req1_y;
  logic [4:0]       req1_cfg;

  logic [WIDTH-1:0] alu_x, alu_y, alu_result;
  logic             alu_zero_x, alu_zero_y, alu_negate;
  logic [1:0]       alu_opcode;
  logic             alu_is_zero, alu_is_negative;

  logic             rsp_valid, rsp_id, rsp_zero, rsp_neg;
  logic [WIDTH-1:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    int               due;
  } exp_t;

  exp_t sb[$];

  // cfg encodings {zero_x, zero_y, negate, opcode}
  localparam logic [4:0] CFG_OR_NEG = 5'b00100;
  localparam logic [4:0] CFG_AND    = 5'b00001;
  localparam logic [4:0] CFG_ADD    = 5'b00010;
  localparam logic [4:0] CFG_ADD_NG = 5'b00110;
  localparam logic [4:0] CFG_SUB    = 5'b00011;
  localparam logic [4:0] CFG_ADD_ZZ = 5'b11010;

  alu_arbiter #(.WIDTH(WIDTH), .LOCK_MAX(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_x          (req0_x),
    .req0_y          (req0_y),
    .req0_cfg        (req0_cfg),
    .req0_lock       (req0_lock),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_x          (req1_x),
    .req1_y          (req1_y),
    .req1_cfg        (req1_cfg),
    .req1_lock       (req1_lock),
    .alu_x           (alu_x),
    .alu_y           (alu_y),
    .alu_zero_x      (alu_zero_x),
    .alu_zero_y      (alu_zero_y),
    .alu_opcode      (alu_opcode),
    .alu_negate      (alu_negate),
    .alu_result      (alu_result),
    .alu_is_zero     (alu_is_zero),
    .alu_is_negative (alu_is_negative),
    .rsp_valid       (rsp_valid),
    .rsp_id          (rsp_id),
    .rsp_result      (rsp_result),
    .rsp_zero        (rsp_zero),
    .rsp_neg         (rsp_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ALU: operands latched at the edge, negate applied afterwards.
  logic [WIDTH-1:0] alu_reg = '0;
  always @(posedge clk) begin
    logic [WIDTH-1:0] a, b;
    a = alu_zero_x ? '0 : alu_x;
    b = alu_zero_y ? '0 : alu_y;
    case (alu_opcode)
      2'd0:    alu_reg <= a | b;
      2'd1:    alu_reg <= a & b;
      2'd2:    alu_reg <= a + b;
      default: alu_reg <= a - b;
    endcase
  end
  assign alu_result      = alu_negate ? ~alu_reg : alu_reg;
  assign alu_is_zero     = (alu_reg == '0);
  assign alu_is_negative = alu_result[WIDTH-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] res, input logic z, input logic n);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.z   = z;
    e.n   = n;
    e.due = cyc + 2;
    sb.push_back(e);
  endtask

  // One clock: check grants and alu_negate mid-cycle, then cross the edge.
  task automatic cycle(input logic r0, input logic r1, input logic neg, input string tag);
    @(negedge clk);
    check({tag, " ready0"}, {31'd0, req0_ready}, {31'd0, r0});
    check({tag, " ready1"}, {31'd0, req1_ready}, {31'd0, r1});
    check({tag, " alu_negate"}, {31'd0, alu_negate}, {31'd0, neg});
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id",      {31'd0, rsp_id},   {31'd0, e.id});
        check("rsp_result",  {16'd0, rsp_result}, {16'd0, e.res});
        check("rsp_zero",    {31'd0, rsp_zero}, {31'd0, e.z});
        check("rsp_neg",     {31'd0, rsp_neg},  {31'd0, e.n});
        check("rsp_latency", cyc, e.due);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b1; req0_x = '0; req0_y = '0; req0_cfg = '0; req0_lock = 1'b0;
    req1_valid = 1'b1; req1_x = '0; req1_y = '0; req1_cfg = '0; req1_lock = 1'b0;

    // Reset state: readies gated off even with both requesters valid.
    repeat (2) @(posedge clk);
    #1;
    check("reset ready0", {31'd0, req0_ready}, 32'd0);
    check("reset ready1", {31'd0, req1_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_result", {16'd0, rsp_result}, 32'd0);
    check("reset alu_negate", {31'd0, alu_negate}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "idle");
    @(negedge clk);
    check("idle alu_x", {16'd0, alu_x}, 32'd0);
    check("idle alu_opcode", {30'd0, alu_opcode}, 32'd0);
    @(posedge clk);
    #1;

    // Single op: 5 + 3.
    req0_valid = 1'b1; req0_x = 16'd5; req0_y = 16'd3; req0_cfg = CFG_ADD;
    push(1'b0, 16'h0008, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, "single");
    req0_valid = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "single drain");

    // Negate timing: OR with negate, then AND without.
    req1_valid = 1'b1; req1_x = 16'h00F0; req1_y = 16'h000F; req1_cfg = CFG_OR_NEG;
    push(1'b1, 16'hFF00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, "neg op1");
    req1_cfg = CFG_AND;
    push(1'b1, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, "neg op2");
    req1_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "neg capture2");
    repeat (2) cycle(1'b0, 1'b0, 1'b0, "neg drain");

    // Round-robin: both valid, 1 - 2.
    req0_valid = 1'b1; req0_x = 16'd1; req0_y = 16'd2; req0_cfg = CFG_SUB;
    req1_valid = 1'b1; req1_x = 16'd1; req1_y = 16'd2; req1_cfg = CFG_SUB;
    for (int i = 0; i < 4; i++) begin
      push(i[0], 16'hFFFF, 1'b0, 1'b1);
      cycle(~i[0], i[0], 1'b0, "rr");
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "rr drain");

    // Lock cap: req0 holds 4 grants, req1 gets one, req0 resumes.
    req0_valid = 1'b1; req0_x = 16'h1234; req0_y = 16'h5678; req0_cfg = CFG_ADD_ZZ; req0_lock = 1'b1;
    req1_valid = 1'b1; req1_x = 16'h4321; req1_y = 16'h8765; req1_cfg = CFG_ADD_ZZ; req1_lock = 1'b0;
    @(negedge clk);
    check("lock alu_zero_x", {31'd0, alu_zero_x}, 32'd1);
    check("lock alu_zero_y", {31'd0, alu_zero_y}, 32'd1);
    check("lock alu_opcode", {30'd0, alu_opcode}, 32'd2);
    @(posedge clk);
    #1;
    // The edge just crossed issued req0's first locked op.
    sb.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, cyc + 1});
    for (int i = 0; i < 6; i++) begin
      logic g1;
      g1 = (i == 3);
      push(g1, 16'h0000, 1'b1, 1'b0);
      cycle(~g1, g1, 1'b0, "lock");
    end
    req0_valid = 1'b0; req0_lock = 1'b0;
    req1_valid = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "lock drain");

    // Leave a non-zero response in the output registers.
    req1_valid = 1'b1; req1_x = 16'd1; req1_y = 16'd2; req1_cfg = CFG_SUB;
    push(1'b1, 16'hFFFF, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, "pre-reset");
    req1_valid = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, "pre-reset drain");

    // Reset mid-flight: issue a negated op, reset in its capture cycle.
    req0_valid = 1'b1; req0_x = 16'h7FFF; req0_y = 16'h0001; req0_cfg = CFG_ADD_NG;
    cycle(1'b1, 1'b0, 1'b0, "flight issue");
    rst        = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("midrst alu_negate", {31'd0, alu_negate}, 32'd0);
    check("midrst rsp_valid",  {31'd0, rsp_valid},  32'd0);
    check("midrst rsp_id",     {31'd0, rsp_id},     32'd0);
    check("midrst rsp_result", {16'd0, rsp_result}, 32'd0);
    check("midrst rsp_neg",    {31'd0, rsp_neg},    32'd0);
    check("midrst rsp_zero",   {31'd0, rsp_zero},   32'd0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, "in reset");
    rst = 1'b0;
    req0_cfg = CFG_ADD;
    push(1'b0, 16'h8000, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, "post-reset");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) cycle(1'b0, 1'b0, 1'b0, "final drain");

    check("scoreboard empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
